shiftin_reader40: RTL

Serial input scanner for the switch panel, the read-side counterpart of the 40-bit and 8-bit output shifter drivers. It drives a daisy-chained parallel-in/serial-out register chain (74HC165 style) using a parallel-load strobe and shift pulses, samples the serial return line, and assembles a WIDTH-bit snapshot. It runs continuously and publishes each completed frame as `data_out`, with a valid strobe and a change strobe. `data_out` feeds the active-low `input_sw` bus of the switch-detect logic.

---
 rtl/shiftin_reader40.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/shiftin_reader40.sv
`default_nettype none
// ============================================================================
// Module      : shiftin_reader40
// Description : Continuous scanner for a daisy-chained parallel-in/serial-out
//               register chain (74HC165 style). Each frame parallel-loads the
//               chain, clocks out WIDTH bits, and publishes the assembled
//               snapshot with one-cycle valid and change strobes.
// Ports       : sys_clk      - system clock, all logic on rising edge
//               rst          - synchronous active-high reset
//               sdata        - serial return from the chain (asynchronous)
//               load_n       - parallel-load strobe to the chain, active low
//               shift_pulse  - shift clock to the chain (rising edge shifts)
//               data_out     - last complete snapshot, bit 0 sampled first
//               frame_valid  - one-cycle pulse when data_out updates
//               data_changed - one-cycle pulse with frame_valid when the new
//                              snapshot differs from the previous one
// Revision    : 1.0 - initial release
// ============================================================================
module shiftin_reader40 #(
    parameter int WIDTH = 40,
    parameter int DIV   = 20
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             sdata,
    output logic             load_n,
    output logic             shift_pulse,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_valid,
    output logic             data_changed
);

    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_cnt_w = $clog2(DIV + 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_div      = c_cnt_w'(DIV);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_REL     = 3'd1,
        S_SAMPLE  = 3'd2,
        S_SHIFT   = 3'd3,
        S_PUBLISH = 3'd4
    } state_t;

    state_t               state_q,        state_d;
    logic [c_cnt_w-1:0]   cnt_q,          cnt_d;
    logic [c_idx_w-1:0]   idx_q,          idx_d;
    logic                 sync1_q,        sync1_d;
    logic                 sync2_q,        sync2_d;
    logic                 load_n_q,       load_n_d;
    logic                 shift_q,        shift_d;
    logic [WIDTH-1:0]     shadow_q,       shadow_d;
    logic [WIDTH-1:0]     data_q,         data_d;
    logic                 frame_valid_q,  frame_valid_d;
    logic                 changed_q,      changed_d;
    logic                 w_tick;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        load_n_d      = load_n_q;
        shift_d       = shift_q;
        shadow_d      = shadow_q;
        data_d        = data_q;
        frame_valid_d = 1'b0;
        changed_d     = 1'b0;

        // Two-flop synchronizer; only sync2_q is ever used downstream.
        sync1_d = sdata;
        sync2_d = sync1_q;

        w_tick = (cnt_q == c_div);
        cnt_d  = w_tick ? '0 : cnt_q + c_cnt_w'(1);

        if (w_tick) begin
            unique case (state_q)
                S_LOAD: begin
                    load_n_d = 1'b0;
                    shift_d  = 1'b0;
                    state_d  = S_REL;
                end
                S_REL: begin
                    load_n_d = 1'b1;
                    state_d  = S_SAMPLE;
                end
                S_SAMPLE: begin
                    shadow_d[idx_q] = sync2_q;
                    shift_d         = 1'b0;
                    state_d         = S_SHIFT;
                end
                S_SHIFT: begin
                    // The last pulse of a frame is harmless: the next load
                    // overwrites the whole chain.
                    shift_d = 1'b1;
                    if (idx_q == c_last_idx) begin
                        state_d = S_PUBLISH;
                    end else begin
                        idx_d   = idx_q + c_idx_w'(1);
                        state_d = S_SAMPLE;
                    end
                end
                S_PUBLISH: begin
                    shift_d       = 1'b0;
                    data_d        = shadow_q;
                    frame_valid_d = 1'b1;
                    changed_d     = (shadow_q != data_q);
                    idx_d         = '0;
                    state_d       = S_LOAD;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            cnt_q         <= '0;
            idx_q         <= '0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            load_n_q      <= 1'b1;
            shift_q       <= 1'b0;
            shadow_q      <= '1;
            data_q        <= '1;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            load_n_q      <= load_n_d;
            shift_q       <= shift_d;
            shadow_q      <= shadow_d;
            data_q        <= data_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
        end
    end

    assign load_n       = load_n_q;
    assign shift_pulse  = shift_q;
    assign data_out     = data_q;
    assign frame_valid  = frame_valid_q;
    assign data_changed = changed_q;

endmodule
`default_nettype wire
